// File: rtl/coproc0_irq_controller.sv
// Edge-triggered interrupt source for the coprocessor-0 interrupt input: pending/mask registers,
// fixed lowest-index priority, and an ack/EOI handshake. Optional macro IRQ_SYNC_EN adds a 2-flop input synchronizer.

module coproc0_irq_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic prev;

  // A new edge in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= irq;
      pend <= (pend & ~clr) | (irq & ~prev);
    end
  end
endmodule

module coproc0_irq_controller #(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_IRQ-1:0]  i_irq,
  input  logic              i_we,
  input  logic [1:0]        i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  input  logic              i_ack,
  output logic              o_coproc0_interrupt,
  output logic [ID_W-1:0]   o_irq_id
);
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, SERVICE = 2'b10} state_t;

  localparam int ST_POS = (N_IRQ <= 8) ? 16 : N_IRQ;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  id_d, cand_id;
  logic [N_IRQ-1:0] irq_s, pending, mask, clr, cand_vec, wdata_n, id_onehot;
  logic             wr_mask, wr_pend, wr_eoi;
  logic [63:0]      status_wide;
  logic [31:0]      unused_status_hi, unused_wdata;

`ifdef IRQ_SYNC_EN
  logic [1:0][N_IRQ-1:0] sync_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], i_irq};
  end
  assign irq_s = sync_q[1];
`else
  assign irq_s = i_irq;
`endif

  assign wr_mask   = i_we && (i_addr == 2'd1);
  assign wr_pend   = i_we && (i_addr == 2'd2);
  assign wr_eoi    = i_we && (i_addr == 2'd3);
  assign wdata_n   = i_wdata[N_IRQ-1:0];
  assign unused_wdata = i_wdata;
  assign id_onehot = N_IRQ'(1) << o_irq_id;
  assign clr       = (wr_pend ? wdata_n : '0)
                   | ((state_q == REQ && i_ack) ? id_onehot : '0);

  coproc0_irq_lane u_lane [N_IRQ-1:0] (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .irq   (irq_s),
    .clr   (clr),
    .pend  (pending)
  );

  assign cand_vec = pending & mask;

  always_comb begin
    cand_id = '0;
    for (int k = N_IRQ-1; k >= 0; k--)
      if (cand_vec[k]) cand_id = ID_W'(k);
  end

  always_comb begin
    state_d = state_q;
    id_d    = o_irq_id;
    case (state_q)
      IDLE:    if (|cand_vec) begin
                 state_d = REQ;
                 id_d    = cand_id;
               end
      // Served id stays frozen; a later higher-priority edge waits for EOI.
      REQ:     if (i_ack) state_d = SERVICE;
               else if (wr_mask && !(|(wdata_n & id_onehot))) state_d = IDLE;
      SERVICE: if (wr_eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      o_irq_id <= '0;
      mask     <= '0;
    end else begin
      state_q  <= state_d;
      o_irq_id <= id_d;
      if (wr_mask) mask <= wdata_n;
    end
  end

  assign o_coproc0_interrupt = (state_q == REQ);

  assign status_wide      = 64'(pending) | (64'(state_q) << ST_POS);
  assign unused_status_hi = status_wide[63:32];

  always_comb begin
    case (i_addr)
      2'd0:    o_rdata = status_wide[31:0];
      2'd1:    o_rdata = 32'(mask);
      2'd2:    o_rdata = 32'(pending);
      default: o_rdata = 32'({state_q, o_irq_id});
    endcase
  end
endmodule

// File: tb/tb_coproc0_irq_controller.sv
// Directed bench for coproc0_irq_controller: per-cycle vector table plus reset/ack corner sequences.

module tb_coproc0_irq_controller;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_irq;
  logic        i_we;
  logic [1:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        i_ack;
  logic        o_coproc0_interrupt;
  logic [2:0]  o_irq_id;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  coproc0_irq_controller #(.N_IRQ(8), .ID_W(3)) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_irq               (i_irq),
    .i_we                (i_we),
    .i_addr              (i_addr),
    .i_wdata             (i_wdata),
    .o_rdata             (o_rdata),
    .i_ack               (i_ack),
    .o_coproc0_interrupt (o_coproc0_interrupt),
    .o_irq_id            (o_irq_id)
  );

  typedef struct {
    logic [7:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic [1:0]  rd;
    logic        e_int;
    logic [2:0]  e_id;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic [7:0] irq, logic we, logic [1:0] addr, logic [31:0] wdata,
                             logic ack, logic [1:0] rd, logic e_int, logic [2:0] e_id, logic [31:0] e_rd);
    vec_t r;
    r.irq = irq; r.we = we; r.addr = addr; r.wdata = wdata; r.ack = ack;
    r.rd = rd; r.e_int = e_int; r.e_id = e_id; r.e_rd = e_rd;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then read register rd just after the rising edge.
  task automatic step(logic [7:0] irq, logic we, logic [1:0] addr, logic [31:0] wdata, logic ack, logic [1:0] rd);
    @(negedge i_clk);
    i_irq = irq; i_we = we; i_addr = addr; i_wdata = wdata; i_ack = ack;
    @(posedge i_clk);
    #1;
    i_we = 1'b0; i_ack = 1'b0; i_addr = rd;
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_irq = '0; i_we = 1'b0; i_addr = '0; i_wdata = '0; i_ack = 1'b0;

    //        irq   we addr wdata  ack rd   int id  rdata
    tbl.push_back(v(8'h00, 1, 2'd1, 32'h00, 0, 2'd1, 0, 3'd0, 32'h0000_0000)); // MASK=0
    tbl.push_back(v(8'h04, 0, 2'd0, 32'h00, 0, 2'd2, 0, 3'd0, 32'h0000_0004)); // masked edge pends
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 0, 2'd0, 0, 3'd0, 32'h0000_0004)); // STATUS idle
    tbl.push_back(v(8'h00, 1, 2'd2, 32'h04, 0, 2'd2, 0, 3'd0, 32'h0000_0000)); // W1C
    tbl.push_back(v(8'h00, 1, 2'd1, 32'hFF, 0, 2'd1, 0, 3'd0, 32'h0000_00FF)); // MASK=FF
    tbl.push_back(v(8'h04, 0, 2'd0, 32'h00, 0, 2'd2, 0, 3'd0, 32'h0000_0004)); // E0
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 0, 2'd0, 1, 3'd2, 32'h0001_0004)); // E1 assert
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 1, 2'd2, 0, 3'd2, 32'h0000_0000)); // ack
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 0, 2'd0, 0, 3'd2, 32'h0002_0000)); // SERVICE
    tbl.push_back(v(8'h00, 1, 2'd3, 32'h00, 0, 2'd3, 0, 3'd2, 32'h0000_0002)); // EOI
    tbl.push_back(v(8'h22, 0, 2'd0, 32'h00, 0, 2'd2, 0, 3'd2, 32'h0000_0022)); // 5 and 1 together
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 0, 2'd3, 1, 3'd1, 32'h0000_0009)); // id 1 wins
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 1, 2'd2, 0, 3'd1, 32'h0000_0020));
    tbl.push_back(v(8'h01, 0, 2'd0, 32'h00, 0, 2'd2, 0, 3'd1, 32'h0000_0021)); // irq0 in SERVICE
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 1, 2'd0, 0, 3'd1, 32'h0002_0021)); // ack ignored
    tbl.push_back(v(8'h00, 1, 2'd3, 32'h5A, 0, 2'd3, 0, 3'd1, 32'h0000_0001)); // EOI
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 0, 2'd2, 1, 3'd0, 32'h0000_0021)); // id 0 next
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 1, 2'd2, 0, 3'd0, 32'h0000_0020));
    tbl.push_back(v(8'h00, 1, 2'd3, 32'h00, 0, 2'd0, 0, 3'd0, 32'h0000_0020));
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 0, 2'd3, 1, 3'd5, 32'h0000_000D)); // id 5 one edge after EOI
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 1, 2'd2, 0, 3'd5, 32'h0000_0000));
    tbl.push_back(v(8'h00, 1, 2'd3, 32'h00, 0, 2'd0, 0, 3'd5, 32'h0000_0000));
    tbl.push_back(v(8'h00, 1, 2'd3, 32'h00, 0, 2'd0, 0, 3'd5, 32'h0000_0000)); // EOI in IDLE ignored
    tbl.push_back(v(8'h08, 0, 2'd0, 32'h00, 0, 2'd2, 0, 3'd5, 32'h0000_0008));
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 0, 2'd0, 1, 3'd3, 32'h0001_0008)); // REQ id 3
    tbl.push_back(v(8'h00, 1, 2'd1, 32'hF7, 0, 2'd0, 0, 3'd3, 32'h0000_0008)); // mask withdrawn
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 0, 2'd1, 0, 3'd3, 32'h0000_00F7));
    tbl.push_back(v(8'h08, 1, 2'd2, 32'h08, 0, 2'd2, 0, 3'd3, 32'h0000_0008)); // set beats W1C
    tbl.push_back(v(8'h00, 1, 2'd1, 32'hFF, 0, 2'd2, 0, 3'd3, 32'h0000_0008));
    tbl.push_back(v(8'h00, 0, 2'd0, 32'h00, 0, 2'd0, 1, 3'd3, 32'h0001_0008)); // back in REQ

    repeat (2) @(posedge i_clk);
    #1;
    check("rst_int", 32'(o_coproc0_interrupt), 32'h0);
    check("rst_id", 32'(o_irq_id), 32'h0);
    i_addr = 2'd0; #1; check("rst_status", o_rdata, 32'h0);
    i_addr = 2'd1; #1; check("rst_mask", o_rdata, 32'h0);
    i_addr = 2'd2; #1; check("rst_pend", o_rdata, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].irq, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].ack, tbl[i].rd);
      check($sformatf("v%0d_int", i), 32'(o_coproc0_interrupt), 32'(tbl[i].e_int));
      check($sformatf("v%0d_id", i), 32'(o_irq_id), 32'(tbl[i].e_id));
      check($sformatf("v%0d_rd", i), o_rdata, tbl[i].e_rd);
    end

    // Reset for one edge while in REQ for id 3.
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    check("mid_rst_int", 32'(o_coproc0_interrupt), 32'h0);
    check("mid_rst_id", 32'(o_irq_id), 32'h0);
    i_addr = 2'd0; #1; check("mid_rst_status", o_rdata, 32'h0);
    i_addr = 2'd1; #1; check("mid_rst_mask", o_rdata, 32'h0);
    i_addr = 2'd2; #1; check("mid_rst_pend", o_rdata, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Stray ack after reset must not move the FSM.
    step(8'h00, 0, 2'd0, 32'h0, 1, 2'd0);
    check("late_ack_int", 32'(o_coproc0_interrupt), 32'h0);
    check("late_ack_status", o_rdata, 32'h0);

    // Enabled edge after reset: two-edge latency to assertion.
    step(8'h00, 1, 2'd1, 32'hFFFF_FF80, 0, 2'd1);
    check("hi_bits_ignored", o_rdata, 32'h80);
    step(8'h80, 0, 2'd0, 32'h0, 0, 2'd0);
    check("e0_no_int", 32'(o_coproc0_interrupt), 32'h0);
    step(8'h80, 0, 2'd0, 32'h0, 0, 2'd3);
    check("e1_int", 32'(o_coproc0_interrupt), 32'h1);
    check("e1_eoi_rd", o_rdata, 32'h0000_000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
endmodule
